cbm2_busctl_seq: RTL and testbench

//  Sequential CBM-II bus controller; successor to the combinational decoder: seg-15 map, RAM windows, registered read mux.

---
 rtl/cbm2_busctl_seq_if.sv | 39 +++
 rtl/cbm2_busctl_seq.sv | 182 ++++++++++++++++++
 tb/tb_cbm2_busctl_seq.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cbm2_busctl_seq_if.sv
// CBM-II bus controller signal bundle: CPU handshake plus RAM, ROM and I/O ports.
// The master side is the environment (CPU and memories); the slave side is the controller.
interface cbm2_busctl_seq_if #(
   parameter int NUM_IO = 8
);
   logic                cpu_req;
   logic [15:0]         cpu_addr;
   logic [7:0]          cpu_seg;
   logic                cpu_we;
   logic [7:0]          cpu_do;
   logic [7:0]          cpu_di;
   logic                ready;
   logic                bus_err;
   logic [24:0]         system_addr;
   logic [7:0]          wr_data;
   logic                ram_req;
   logic                ram_we;
   logic                ram_ack;
   logic [7:0]          ram_data;
   logic [3:0]          rom_cs;
   logic [31:0]         rom_data;
   logic [NUM_IO-1:0]   io_cs;
   logic                io_we;
   logic [8*NUM_IO-1:0] io_data;

   modport master (
      output cpu_req, cpu_addr, cpu_seg, cpu_we, cpu_do,
      output ram_ack, ram_data, rom_data, io_data,
      input  cpu_di, ready, bus_err, system_addr, wr_data,
      input  ram_req, ram_we, rom_cs, io_cs, io_we
   );

   modport slave (
      input  cpu_req, cpu_addr, cpu_seg, cpu_we, cpu_do,
      input  ram_ack, ram_data, rom_data, io_data,
      output cpu_di, ready, bus_err, system_addr, wr_data,
      output ram_req, ram_we, rom_cs, io_cs, io_we
   );
endinterface

// File: rtl/cbm2_busctl_seq.sv
// Sequential CBM-II bus controller: decodes one CPU access at a time into RAM, ROM or I/O,
// waits for ack / fixed latency / wait states, and returns a registered byte with a one-cycle ready.
module cbm2_busctl_seq #(
   parameter int NUM_IO  = 8,
   parameter int IO_WAIT = 2,
   parameter int ROM_LAT = 1,
   parameter int RAM_TMO = 64
) (
   input  logic             i_clk_sys,
   input  logic             i_reset_n,
   input  logic             i_model,
   input  logic [1:0]       i_ram_size,
   input  logic             i_ipc_ram_en,
   cbm2_busctl_seq_if.slave bus
);
   typedef enum logic [1:0] {K_UNM, K_RAM, K_ROM, K_IO} kind_t;
   typedef enum logic [2:0] {S_IDLE, S_RAM_WAIT, S_ROM_WAIT, S_IO_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic [7:0]        r_cnt;
   logic              r_we;
   logic [1:0]        r_rom_sel;

   kind_t             w_kind;
   logic [1:0]        w_rom_sel;
   logic [2:0]        w_io_pg;
   logic [NUM_IO-1:0] w_io_onehot;
   logic [7:0]        w_io_rd;
   logic [7:0]        w_rom_rd;
   logic [7:0]        w_seg;
   logic [15:0]       w_addr;

   assign w_seg  = bus.cpu_seg;
   assign w_addr = bus.cpu_addr;
   assign w_io_pg = w_addr[10:8];

   // Address decode of the live CPU request; only consumed in IDLE when cpu_req is accepted.
   always_comb begin
      w_kind    = K_UNM;
      w_rom_sel = 2'd0;
      if (w_seg == 8'h0F) begin
         case (w_addr[15:12])
            4'h0: if (!w_addr[11] || i_ipc_ram_en) w_kind = K_RAM;
            4'h8, 4'h9: begin w_kind = K_ROM; w_rom_sel = 2'd0; end
            4'hA, 4'hB: begin w_kind = K_ROM; w_rom_sel = 2'd1; end
            4'hC: if (!i_model) begin w_kind = K_ROM; w_rom_sel = 2'd2; end
            4'hD: begin
               if (!w_addr[11]) begin
                  if (!w_addr[10] || i_model) w_kind = K_RAM;
               end else if (int'(w_io_pg) < NUM_IO) begin
                  w_kind = K_IO;
               end
            end
            4'hE, 4'hF: begin w_kind = K_ROM; w_rom_sel = 2'd3; end
            default: w_kind = K_UNM;
         endcase
      end else begin
         case (i_ram_size)
            2'd0: if (i_model ? (w_seg >= 8'd1 && w_seg <= 8'd2) : (w_seg <= 8'd1)) w_kind = K_RAM;
            2'd1: if (i_model ? (w_seg >= 8'd1 && w_seg <= 8'd4) : (w_seg <= 8'd3)) w_kind = K_RAM;
            default: w_kind = K_RAM;
         endcase
      end
   end

   always_comb begin
      w_io_onehot = '0;
      for (int n = 0; n < NUM_IO; n++)
         if (int'(w_io_pg) == n) w_io_onehot[n] = 1'b1;
   end

   always_comb begin
      w_io_rd = 8'hFF;
      for (int n = 0; n < NUM_IO; n++)
         if (bus.io_cs[n]) w_io_rd = bus.io_data[8*n +: 8];
   end

   always_comb begin
      case (r_rom_sel)
         2'd0:    w_rom_rd = bus.rom_data[7:0];
         2'd1:    w_rom_rd = bus.rom_data[15:8];
         2'd2:    w_rom_rd = bus.rom_data[23:16];
         default: w_rom_rd = bus.rom_data[31:24];
      endcase
   end

   always_ff @(posedge i_clk_sys) begin
      if (!i_reset_n) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         r_we            <= 1'b0;
         r_rom_sel       <= 2'd0;
         bus.cpu_di      <= 8'hFF;
         bus.ready       <= 1'b0;
         bus.bus_err     <= 1'b0;
         bus.system_addr <= '0;
         bus.wr_data     <= '0;
         bus.ram_req     <= 1'b0;
         bus.ram_we      <= 1'b0;
         bus.rom_cs      <= '0;
         bus.io_cs       <= '0;
         bus.io_we       <= 1'b0;
      end else begin
         bus.ready <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.cpu_req) begin
               bus.system_addr <= {1'b0, w_seg, w_addr};
               bus.wr_data     <= bus.cpu_do;
               r_we            <= bus.cpu_we;
               r_cnt           <= '0;
               case (w_kind)
                  K_RAM: begin
                     r_state     <= S_RAM_WAIT;
                     bus.ram_req <= 1'b1;
                     bus.ram_we  <= bus.cpu_we;
                  end
                  K_ROM: begin
                     // ROM writes are dropped and complete like an unmapped access.
                     if (bus.cpu_we) begin
                        r_state   <= S_DONE;
                        bus.ready <= 1'b1;
                     end else begin
                        r_state    <= S_ROM_WAIT;
                        r_rom_sel  <= w_rom_sel;
                        bus.rom_cs <= 4'b0001 << w_rom_sel;
                     end
                  end
                  K_IO: begin
                     r_state   <= S_IO_WAIT;
                     bus.io_cs <= w_io_onehot;
                     bus.io_we <= bus.cpu_we && (IO_WAIT == 0);
                  end
                  default: begin
                     r_state   <= S_DONE;
                     bus.ready <= 1'b1;
                  end
               endcase
            end
            S_RAM_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (bus.ram_ack) begin
                  bus.ram_req <= 1'b0;
                  bus.ram_we  <= 1'b0;
                  if (!r_we) bus.cpu_di <= bus.ram_data;
                  r_state   <= S_DONE;
                  bus.ready <= 1'b1;
               end else if (r_cnt == 8'(RAM_TMO - 1)) begin
                  bus.ram_req <= 1'b0;
                  bus.ram_we  <= 1'b0;
                  bus.bus_err <= 1'b1;
                  r_state     <= S_DONE;
                  bus.ready   <= 1'b1;
               end
            end
            S_ROM_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'(ROM_LAT - 1)) begin
                  bus.rom_cs <= '0;
                  bus.cpu_di <= w_rom_rd;
                  r_state    <= S_DONE;
                  bus.ready  <= 1'b1;
               end
            end
            S_IO_WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               if (r_cnt == 8'(IO_WAIT)) begin
                  bus.io_cs <= '0;
                  bus.io_we <= 1'b0;
                  if (!r_we) bus.cpu_di <= w_io_rd;
                  r_state   <= S_DONE;
                  bus.ready <= 1'b1;
               end else begin
                  // Strobe only during the final wait cycle so the device sees settled select/data.
                  bus.io_we <= r_we && (r_cnt == 8'(IO_WAIT - 1));
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cbm2_busctl_seq.sv
// Directed bench for cbm2_busctl_seq: decode map, RAM ack/timeout, ROM latency, I/O wait states,
// write handling, dropped requests while busy and mid-access reset.
module tb_cbm2_busctl_seq;
   logic       clk;
   logic       rst_n;
   logic       model;
   logic [1:0] ram_size;
   logic       ipc;
   int         checks;
   int         errors;

   cbm2_busctl_seq_if #(.NUM_IO(8)) bus ();

   cbm2_busctl_seq #(.NUM_IO(8), .IO_WAIT(2), .ROM_LAT(1), .RAM_TMO(64)) dut (
      .i_clk_sys   (clk),
      .i_reset_n   (rst_n),
      .i_model     (model),
      .i_ram_size  (ram_size),
      .i_ipc_ram_en(ipc),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive_req(input logic [7:0] seg, input logic [15:0] addr, input logic we, input logic [7:0] d);
      bus.cpu_req  = 1'b1;
      bus.cpu_seg  = seg;
      bus.cpu_addr = addr;
      bus.cpu_we   = we;
      bus.cpu_do   = d;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.cpu_di, bus.ready, bus.ram_req, bus.bus_err, bus.rom_cs, bus.io_cs, bus.io_we} !== {8'hFF, 3'b000, 4'h0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset got di=%h rdy=%b rreq=%b err=%b rom=%b io=%h iowe=%b", bus.cpu_di, bus.ready, bus.ram_req, bus.bus_err, bus.rom_cs, bus.io_cs, bus.io_we);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_rom_read;
      drive_req(8'h0F, 16'hE000, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      checks++;
      if ({bus.rom_cs, bus.ready} !== {4'b1000, 1'b0}) begin
         errors++; $display("FAIL rom_cs_kernal got rom=%b rdy=%b exp 1000/0", bus.rom_cs, bus.ready);
      end
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.cpu_di, bus.rom_cs} !== {1'b1, 8'h4C, 4'h0}) begin
         errors++; $display("FAIL rom_read_E got rdy=%b di=%h rom=%b exp 1/4c/0000", bus.ready, bus.cpu_di, bus.rom_cs);
      end
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0) begin errors++; $display("FAIL rom_ready_one_cycle got %b exp 0", bus.ready); end
      drive_req(8'h0F, 16'hA123, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      checks++;
      if (bus.rom_cs !== 4'b0010) begin errors++; $display("FAIL rom_cs_basicA got %b exp 0010", bus.rom_cs); end
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.cpu_di} !== {1'b1, 8'h2A}) begin
         errors++; $display("FAIL rom_read_A got rdy=%b di=%h exp 1/2a", bus.ready, bus.cpu_di);
      end
      @(negedge clk);
   endtask

   task automatic test_ram_read;
      logic bad;
      model = 1'b1; ram_size = 2'd0;
      drive_req(8'h01, 16'h1234, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      checks++;
      if ({bus.ram_req, bus.ram_we, bus.system_addr} !== {2'b10, 25'h0011234}) begin
         errors++; $display("FAIL ram_accept got rreq=%b rwe=%b sa=%h exp 1/0/0011234", bus.ram_req, bus.ram_we, bus.system_addr);
      end
      bus.cpu_addr = 16'hFFFF; bus.cpu_seg = 8'h0F;
      bad = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         @(negedge clk);
         if (bus.ram_req !== 1'b1 || bus.ready !== 1'b0 || bus.system_addr !== 25'h0011234) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL ram_hold got bad=%b exp 0", bad); end
      @(negedge clk);
      bus.ram_ack = 1'b1; bus.ram_data = 8'h5A;
      @(negedge clk);
      bus.ram_ack = 1'b0; bus.ram_data = 8'h00;
      checks++;
      if ({bus.ready, bus.cpu_di, bus.ram_req} !== {1'b1, 8'h5A, 1'b0}) begin
         errors++; $display("FAIL ram_read got rdy=%b di=%h rreq=%b exp 1/5a/0", bus.ready, bus.cpu_di, bus.ram_req);
      end
      @(negedge clk);
      drive_req(8'h03, 16'h1234, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      checks++;
      if ({bus.ready, bus.cpu_di, bus.ram_req} !== {1'b1, 8'h5A, 1'b0}) begin
         errors++; $display("FAIL seg3_open_bus got rdy=%b di=%h rreq=%b exp 1/5a/0", bus.ready, bus.cpu_di, bus.ram_req);
      end
      @(negedge clk);
   endtask

   task automatic test_io;
      logic bad;
      logic [2:0] we_seen;
      drive_req(8'h0F, 16'hDC0D, 1'b0, 8'h00);
      bad = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bus.cpu_req = 1'b0;
         if (bus.io_cs !== 8'h10 || bus.ready !== 1'b0 || bus.io_we !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin errors++; $display("FAIL io_cs_hold got bad=%b exp 0", bad); end
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.cpu_di, bus.io_cs} !== {1'b1, 8'h81, 8'h00}) begin
         errors++; $display("FAIL io_read got rdy=%b di=%h io=%h exp 1/81/00", bus.ready, bus.cpu_di, bus.io_cs);
      end
      @(negedge clk);
      drive_req(8'h0F, 16'hDA00, 1'b1, 8'h33);
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bus.cpu_req = 1'b0;
         we_seen[i-1] = bus.io_we;
      end
      checks++;
      if (we_seen !== 3'b100) begin errors++; $display("FAIL io_we_last got %b exp 100", we_seen); end
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.cpu_di} !== {1'b1, 8'h81}) begin
         errors++; $display("FAIL io_write_di got rdy=%b di=%h exp 1/81", bus.ready, bus.cpu_di);
      end
      @(negedge clk);
   endtask

   task automatic map_chk(input string nm, input logic [7:0] seg, input logic [15:0] addr,
                          input logic mdl, input logic [1:0] sz, input logic ipe,
                          input logic e_unm, input logic e_ram, input logic [3:0] e_rom, input logic [7:0] e_io);
      logic [13:0] got;
      logic        seen;
      int          n;
      model = mdl; ram_size = sz; ipc = ipe;
      drive_req(seg, addr, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      got = {bus.ready, bus.ram_req, bus.rom_cs, bus.io_cs};
      checks++;
      if (got !== {e_unm, e_ram, e_rom, e_io}) begin
         errors++; $display("FAIL map_%s got %b exp %b", nm, got, {e_unm, e_ram, e_rom, e_io});
      end
      bus.ram_ack = bus.ram_req;
      seen = bus.ready;
      n = 0;
      while (!seen && n < 10) begin
         @(negedge clk);
         bus.ram_ack = 1'b0;
         seen = bus.ready;
         n++;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL map_%s_done got ready=0 exp 1", nm); end
      @(negedge clk);
   endtask

   task automatic test_map;
      map_chk("f1000",  8'h0F, 16'h1000, 0, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("f8000",  8'h0F, 16'h8000, 0, 0, 0, 0, 0, 4'h1, 8'h00);
      map_chk("fc000p", 8'h0F, 16'hC000, 0, 0, 0, 0, 0, 4'h4, 8'h00);
      map_chk("fc000b", 8'h0F, 16'hC000, 1, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("fd400p", 8'h0F, 16'hD400, 0, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("fd400b", 8'h0F, 16'hD400, 1, 0, 0, 0, 1, 4'h0, 8'h00);
      map_chk("fd200",  8'h0F, 16'hD200, 0, 0, 0, 0, 1, 4'h0, 8'h00);
      map_chk("f0800n", 8'h0F, 16'h0800, 0, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("f0800y", 8'h0F, 16'h0800, 0, 0, 1, 0, 1, 4'h0, 8'h00);
      map_chk("f0400",  8'h0F, 16'h0400, 0, 0, 0, 0, 1, 4'h0, 8'h00);
      map_chk("fdf00",  8'h0F, 16'hDF00, 0, 0, 0, 0, 0, 4'h0, 8'h80);
      map_chk("s2b0",   8'h02, 16'h0000, 1, 0, 0, 0, 1, 4'h0, 8'h00);
      map_chk("s2p0",   8'h02, 16'h0000, 0, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("s0b0",   8'h00, 16'h0000, 1, 0, 0, 1, 0, 4'h0, 8'h00);
      map_chk("s4b1",   8'h04, 16'h0000, 1, 1, 0, 0, 1, 4'h0, 8'h00);
      map_chk("s4p1",   8'h04, 16'h0000, 0, 1, 0, 1, 0, 4'h0, 8'h00);
      map_chk("s3p1",   8'h03, 16'h0000, 0, 1, 0, 0, 1, 4'h0, 8'h00);
      map_chk("s80z2",  8'h80, 16'h0000, 0, 2, 0, 0, 1, 4'h0, 8'h00);
      map_chk("sfez3",  8'hFE, 16'h0000, 1, 3, 0, 0, 1, 4'h0, 8'h00);
   endtask

   task automatic test_timeout;
      int  n;
      logic seen;
      model = 1'b0; ram_size = 2'd0; ipc = 1'b0;
      drive_req(8'h0F, 16'hE000, 1'b0, 8'h00);
      @(negedge clk); bus.cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      drive_req(8'h00, 16'h0100, 1'b0, 8'h00);
      n = 0; seen = 1'b0;
      while (!seen && n < 80) begin
         @(negedge clk);
         bus.cpu_req = 1'b0;
         n++;
         seen = bus.ready;
      end
      checks++;
      if (n !== 65) begin errors++; $display("FAIL tmo_latency got %0d exp 65", n); end
      checks++;
      if ({bus.bus_err, bus.cpu_di, bus.ram_req} !== {1'b1, 8'h4C, 1'b0}) begin
         errors++; $display("FAIL tmo_state got err=%b di=%h rreq=%b exp 1/4c/0", bus.bus_err, bus.cpu_di, bus.ram_req);
      end
      @(negedge clk);
      bus.ram_ack = 1'b1; bus.ram_data = 8'h99;
      @(negedge clk);
      bus.ram_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.cpu_di} !== {1'b0, 8'h4C}) begin
         errors++; $display("FAIL late_ack got rdy=%b di=%h exp 0/4c", bus.ready, bus.cpu_di);
      end
      drive_req(8'h0F, 16'hE000, 1'b0, 8'h00);
      @(negedge clk); bus.cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.bus_err} !== 2'b11) begin
         errors++; $display("FAIL bus_err_sticky got rdy=%b err=%b exp 1/1", bus.ready, bus.bus_err);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int rdy_cnt;
      logic rom_hit;
      drive_req(8'h0F, 16'h8000, 1'b1, 8'h12);
      @(negedge clk);
      checks++;
      if ({bus.ready, bus.rom_cs} !== {1'b1, 4'h0}) begin
         errors++; $display("FAIL rom_write got rdy=%b rom=%b exp 1/0000", bus.ready, bus.rom_cs);
      end
      drive_req(8'h0F, 16'hE000, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      rdy_cnt = 0; rom_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.ready) rdy_cnt++;
         if (bus.rom_cs != 4'h0) rom_hit = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (rdy_cnt !== 0 || rom_hit !== 1'b0 || bus.cpu_di !== 8'h4C) begin
         errors++; $display("FAIL busy_req_dropped got rdy=%0d rom=%b di=%h exp 0/0/4c", rdy_cnt, rom_hit, bus.cpu_di);
      end
      drive_req(8'h0F, 16'hD000, 1'b1, 8'h77);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      checks++;
      if ({bus.ram_req, bus.ram_we, bus.wr_data} !== {2'b11, 8'h77}) begin
         errors++; $display("FAIL ram_write got rreq=%b rwe=%b wd=%h exp 1/1/77", bus.ram_req, bus.ram_we, bus.wr_data);
      end
      @(negedge clk);
      drive_req(8'h0F, 16'hE000, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      bus.ram_ack = 1'b1; bus.ram_data = 8'hEE;
      @(negedge clk);
      bus.ram_ack = 1'b0;
      checks++;
      if ({bus.ready, bus.cpu_di, bus.ram_we} !== {1'b1, 8'h4C, 1'b0}) begin
         errors++; $display("FAIL ram_write_done got rdy=%b di=%h rwe=%b exp 1/4c/0", bus.ready, bus.cpu_di, bus.ram_we);
      end
      rdy_cnt = 0; rom_hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.ready) rdy_cnt++;
         if (bus.rom_cs != 4'h0) rom_hit = 1'b1;
      end
      checks++;
      if (rdy_cnt !== 0 || rom_hit !== 1'b0) begin
         errors++; $display("FAIL ram_busy_req_dropped got rdy=%0d rom=%b exp 0/0", rdy_cnt, rom_hit);
      end
   endtask

   task automatic test_reset_abort;
      int rdy_cnt;
      drive_req(8'h0F, 16'hDC00, 1'b0, 8'h00);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.io_cs, bus.io_we, bus.ready, bus.cpu_di, bus.bus_err, bus.ram_req} !== {8'h00, 2'b00, 8'hFF, 2'b00}) begin
         errors++; $display("FAIL reset_abort got io=%h iowe=%b rdy=%b di=%h err=%b rreq=%b", bus.io_cs, bus.io_we, bus.ready, bus.cpu_di, bus.bus_err, bus.ram_req);
      end
      rst_n = 1'b1;
      rdy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.ready) rdy_cnt++;
      end
      checks++;
      if (rdy_cnt !== 0) begin errors++; $display("FAIL abort_no_ready got %0d exp 0", rdy_cnt); end
   endtask

   initial begin
      checks = 0; errors = 0;
      model = 1'b0; ram_size = 2'd0; ipc = 1'b0; rst_n = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_seg = '0; bus.cpu_we = 1'b0; bus.cpu_do = '0;
      bus.ram_ack = 1'b0; bus.ram_data = '0;
      bus.rom_data = {8'h4C, 8'h3C, 8'h2A, 8'h18};
      for (int n = 0; n < 8; n++) bus.io_data[8*n +: 8] = 8'h70 + 8'(n);
      bus.io_data[39:32] = 8'h81;
      test_reset;
      test_rom_read;
      test_ram_read;
      test_io;
      test_map;
      test_timeout;
      test_back_to_back;
      test_reset_abort;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
